// File: rtl/mult_slot_arbiter_pkg.sv
// mult_slot_arbiter_pkg: FSM state encoding and default sizing shared by the slot arbiter files.
package mult_slot_arbiter_pkg;
  typedef enum logic [1:0] {IDLE, ISSUE, WAIT, RESP} state_t;
  localparam int DEF_WIDTH = 64;
  localparam int DEF_SLOT_CYCLES = 70;
  localparam int DEF_DONE_LAT = 65;
endpackage

// File: rtl/rr_arb2.sv
// rr_arb2: two-way round-robin arbiter; holds the priority pointer and the registered winner.
module rr_arb2 (
  input  logic clk,
  input  logic rst,
  input  logic req0,
  input  logic req1,
  input  logic load,
  input  logic issue,
  output logic pick,
  output logic sel,
  output logic gnt0,
  output logic gnt1
);
  logic prio;
  assign pick = (req0 && req1) ? prio : req1;
  assign gnt0 = issue && !sel;
  assign gnt1 = issue && sel;
  // The loser of each arbitration gets priority for the next contested one.
  always_ff @(posedge clk or negedge rst)
    if (!rst) begin
      prio <= 1'b0;
      sel <= 1'b0;
    end else if (load && (req0 || req1)) begin
      sel <= pick;
      prio <= ~pick;
    end
endmodule

// File: rtl/mult_slot_arbiter.sv
// mult_slot_arbiter: fixed-slot two-requester front end for a shared multi-cycle multiplier.
// Optional MULT_SLOT_LEAK_CHECK_EN also flags a first mul_done arriving off the expected count.
module mult_slot_arbiter
  import mult_slot_arbiter_pkg::*;
#(
  parameter int WIDTH = DEF_WIDTH,
  parameter int SLOT_CYCLES = DEF_SLOT_CYCLES,
  parameter int DONE_LAT = DEF_DONE_LAT
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               req0,
  input  logic               req1,
  input  logic [WIDTH-1:0]   a0,
  input  logic [WIDTH-1:0]   b0,
  input  logic [WIDTH-1:0]   a1,
  input  logic [WIDTH-1:0]   b1,
  output logic               gnt0,
  output logic               gnt1,
  output logic               resp_valid0,
  output logic               resp_valid1,
  output logic [2*WIDTH-1:0] resp0,
  output logic [2*WIDTH-1:0] resp1,
  output logic               mul_start,
  output logic [WIDTH-1:0]   mul_a,
  output logic [WIDTH-1:0]   mul_b,
  input  logic [2*WIDTH-1:0] mul_product,
  input  logic               mul_done,
  output logic               busy,
  output logic               err
);
  localparam int CW = $clog2(SLOT_CYCLES);
  if (SLOT_CYCLES < DONE_LAT + 1) begin : g_bad_slot
    $error("SLOT_CYCLES must be at least DONE_LAT+1");
  end
  state_t state, state_n;
  logic [CW-1:0] cnt;
  logic [2*WIDTH-1:0] cap, res;
  logic done_seen, pick, sel, idle, issue, last, cap_now, leak, start;
  assign idle = state == IDLE;
  assign issue = state == ISSUE;
  assign start = idle && (req0 || req1);
  assign mul_start = issue;
  assign busy = !idle;
  assign resp_valid0 = state == RESP && !sel;
  assign resp_valid1 = state == RESP && sel;
  rr_arb2 u_arb (
    .clk(clk), .rst(rst), .req0(req0), .req1(req1), .load(idle), .issue(issue),
    .pick(pick), .sel(sel), .gnt0(gnt0), .gnt1(gnt1)
  );
  always_comb begin
    last = state == WAIT && cnt == CW'(SLOT_CYCLES - 1);
    cap_now = state == WAIT && mul_done && !done_seen;
    // A done landing on the final WAIT cycle must still reach the response.
    res = done_seen ? cap : cap_now ? mul_product : '0;
    state_n = idle ? (start ? ISSUE : IDLE) : issue ? WAIT : state == WAIT ? (last ? RESP : WAIT) : IDLE;
  end
`ifdef MULT_SLOT_LEAK_CHECK_EN
  assign leak = cap_now && cnt != CW'(DONE_LAT - 1);
`else
  assign leak = 1'b0;
`endif
  always_ff @(posedge clk or negedge rst)
    if (!rst) begin
      state <= IDLE;
      cnt <= '0;
      cap <= '0;
      done_seen <= 1'b0;
      mul_a <= '0;
      mul_b <= '0;
      resp0 <= '0;
      resp1 <= '0;
      err <= 1'b0;
    end else begin
      state <= state_n;
      cnt <= state == WAIT ? cnt + CW'(1) : '0;
      if (start) begin
        mul_a <= pick ? a1 : a0;
        mul_b <= pick ? b1 : b0;
        done_seen <= 1'b0;
      end
      if (cap_now) begin
        cap <= mul_product;
        done_seen <= 1'b1;
      end
      if (last && !sel) resp0 <= res;
      if (last && sel) resp1 <= res;
      if ((last && !done_seen && !cap_now) || leak) err <= 1'b1;
    end
endmodule
